// File: rtl/urv_fetch_pkg.sv
// Shared types for the uRV fetch stage: FSM encoding, buffer payload layout
// and PC alignment helper.
package urv_fetch_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned ENTRY_W = 2 * XLEN;

    typedef enum logic [1:0] {
        FETCH_RESET = 2'd0,
        FETCH_RUN   = 2'd1,
        FETCH_FLUSH = 2'd2
    } fetch_state_e;

    // One buffered instruction: word plus the PC it was fetched from.
    typedef struct packed {
        logic [XLEN-1:0] ir;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/urv_fetch_buffer.sv
// Small synchronous FIFO holding fetched {ir, pc} entries until decode takes them.
// Flush empties it in one cycle and wins over a concurrent write or pop.
module urv_fetch_buffer
    import urv_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       wr_i,
    input  logic [ENTRY_W-1:0]         wr_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output logic [$clog2(DEPTH+1)-1:0] occupancy_o,
    output logic [ENTRY_W-1:0]         head_o,
    output logic                       empty_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]      rd_ptr_q;
    logic [PW-1:0]      wr_ptr_q;
    logic [CW-1:0]      count_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(wr_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset; occupancy alone qualifies the contents.
    always_ff @(posedge clk_i) begin
        if (wr_i && !flush_i && !rst_i) mem_q[wr_ptr_q] <= wr_data_i;
    end

    assign head_o      = mem_q[rd_ptr_q];
    assign occupancy_o = count_q;
    assign empty_o     = (count_q == '0);

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (wr_i && !pop_i && !flush_i) |-> (count_q < CW'(DEPTH)));
    a_no_underflow: assert property (@(posedge clk_i) disable iff (rst_i)
        (pop_i && !flush_i) |-> (count_q != '0));

endmodule

// File: rtl/urv_fetch.sv
// uRV instruction fetch: keeps the fetch PC, issues pipelined in-order reads,
// buffers responses for decode and discards responses orphaned by a redirect.
module urv_fetch
    import urv_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned DEPTH        = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic [31:0] im_addr_o,
    output logic        im_rd_o,
    input  logic        im_ready_i,
    input  logic [31:0] im_data_i,
    input  logic        im_valid_i,
    input  logic        x_bra_i,
    input  logic [31:0] x_bra_target_i,
    input  logic        f_stall_i,
    output logic        f_valid_o,
    output logic [31:0] f_ir_o,
    output logic [31:0] f_pc_o
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_state_e  state_q, state_d;
    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   resp_pc_q, resp_pc_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [CW-1:0] stale_q, stale_d;
    logic [CW-1:0] occupancy;
    logic [CW:0]   inflight_c;
    logic          pop_c, buf_pop_c, accept_c, rsp_c, buf_wr_c, buf_empty;
    logic [ENTRY_W-1:0] head_raw;
    fetch_entry_t  head_e, wr_e, hold_q;

    urv_fetch_buffer #(.DEPTH(DEPTH)) u_buffer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .wr_i        (buf_wr_c),
        .wr_data_i   (wr_e),
        .pop_i       (buf_pop_c),
        .flush_i     (x_bra_i),
        .occupancy_o (occupancy),
        .head_o      (head_raw),
        .empty_o     (buf_empty)
    );

    assign head_e = fetch_entry_t'(head_raw);
    assign wr_e   = '{ir: im_data_i, pc: resp_pc_q};

    // Next-state, issue and response bookkeeping.
    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        stale_d       = stale_q;

        pop_c      = f_valid_o && !f_stall_i;
        buf_pop_c  = pop_c && !x_bra_i;
        inflight_c = (CW+1)'(outstanding_q) + (CW+1)'(occupancy) - (CW+1)'(pop_c);
        im_rd_o    = (state_q != FETCH_RESET) && !x_bra_i && (inflight_c < (CW+1)'(DEPTH));
        accept_c   = im_rd_o && im_ready_i;
        rsp_c      = im_valid_i && (outstanding_q != '0);
        buf_wr_c   = rsp_c && (stale_q == '0) && !x_bra_i;

        outstanding_d = outstanding_q + CW'(accept_c) - CW'(rsp_c);

        if (x_bra_i) begin
            fetch_pc_d = word_align(x_bra_target_i);
            resp_pc_d  = word_align(x_bra_target_i);
            stale_d    = outstanding_q - CW'(rsp_c);
        end else begin
            if (accept_c) fetch_pc_d = fetch_pc_q + 32'd4;
            if (buf_wr_c) resp_pc_d = resp_pc_q + 32'd4;
            if (rsp_c && (stale_q != '0)) stale_d = stale_q - CW'(1);
        end

        case (state_q)
            FETCH_RESET: state_d = FETCH_RUN;
            FETCH_RUN, FETCH_FLUSH: begin
                if (x_bra_i) state_d = (stale_d != '0) ? FETCH_FLUSH : FETCH_RUN;
                else if (stale_d == '0) state_d = FETCH_RUN;
            end
            default: state_d = FETCH_RESET;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= FETCH_RESET;
            fetch_pc_q    <= RESET_VECTOR;
            resp_pc_q     <= RESET_VECTOR;
            outstanding_q <= '0;
            stale_q       <= '0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            stale_q       <= stale_d;
        end
    end

    // Last presented entry, shown while the buffer is empty.
    always_ff @(posedge clk_i) begin
        if (rst_i) hold_q <= '{ir: 32'h0, pc: RESET_VECTOR};
        else if (!buf_empty) hold_q <= head_e;
    end

    assign im_addr_o = word_align(fetch_pc_q);
    assign f_valid_o = !buf_empty;
    assign f_ir_o    = buf_empty ? hold_q.ir : head_e.ir;
    assign f_pc_o    = buf_empty ? hold_q.pc : head_e.pc;

    a_rsp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
        im_valid_i |-> (outstanding_q != '0));

endmodule

// File: tb/tb_urv_fetch.sv
// Bench for urv_fetch: randomized memory/stall/redirect traffic checked against
// an instruction-stream model (expected issue and delivery PCs, memory contents).
module tb_urv_fetch;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] im_addr_o;
    logic        im_rd_o;
    logic        im_ready_i;
    logic [31:0] im_data_i;
    logic        im_valid_i;
    logic        x_bra_i;
    logic [31:0] x_bra_target_i;
    logic        f_stall_i;
    logic        f_valid_o;
    logic [31:0] f_ir_o;
    logic [31:0] f_pc_o;

    always #5 clk_i = ~clk_i;

    urv_fetch #(.RESET_VECTOR(32'h0000_0000), .DEPTH(2)) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .im_addr_o      (im_addr_o),
        .im_rd_o        (im_rd_o),
        .im_ready_i     (im_ready_i),
        .im_data_i      (im_data_i),
        .im_valid_i     (im_valid_i),
        .x_bra_i        (x_bra_i),
        .x_bra_target_i (x_bra_target_i),
        .f_stall_i      (f_stall_i),
        .f_valid_o      (f_valid_o),
        .f_ir_o         (f_ir_o),
        .f_pc_o         (f_pc_o)
    );

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    mreq_t       memq[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int unsigned cyc = 0;
    int unsigned stall_pct = 0, rdy_pct = 100, lat_min = 1, lat_max = 1;
    int unsigned n_pop = 0;
    logic [31:0] exp_pc, issue_pc, last_pc, last_ir, hold_addr, prev_pop_pc;
    logic [31:0] first_pop_pc, last_addr;
    bit          hold_pend, arm_first, wrap_seen, last_rd;
    bit          rd_log [64];
    bit          val_log [64];

    // Memory image: an odd multiplier keeps every address's word distinct.
    function automatic logic [31:0] mdata(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1; x_bra_i = 1'b0; x_bra_target_i = '0; im_valid_i = 1'b0;
        im_ready_i = 1'b1; f_stall_i = 1'b0; im_data_i = '0;
        @(posedge clk_i);
        @(negedge clk_i);
        chk("rst_im_rd", 32'(im_rd_o), 32'd0);
        chk("rst_f_valid", 32'(f_valid_o), 32'd0);
        chk("rst_f_ir", f_ir_o, 32'h0);
        chk("rst_f_pc", f_pc_o, 32'h0);
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        memq.delete();
        cyc = 0; exp_pc = '0; issue_pc = '0; last_pc = '0; last_ir = '0;
        hold_pend = 0; arm_first = 0;
    endtask

    // One clock cycle: drive inputs, compare outputs against the stream model.
    task automatic step(input logic bra, input logic [31:0] tgt);
        x_bra_i        = bra;
        x_bra_target_i = tgt;
        f_stall_i      = ($urandom_range(99) < stall_pct);
        im_ready_i     = ($urandom_range(99) < rdy_pct);
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            im_valid_i = 1'b1;
            im_data_i  = mdata(memq[0].addr);
            void'(memq.pop_front());
        end else begin
            im_valid_i = 1'b0;
            im_data_i  = $urandom;
        end
        @(negedge clk_i);
        if (cyc < 64) begin
            rd_log[cyc]  = im_rd_o;
            val_log[cyc] = f_valid_o;
        end
        last_rd = im_rd_o; last_addr = im_addr_o;
        if (bra) chk("rd_on_bra", 32'(im_rd_o), 32'd0);
        if (hold_pend && !bra) begin
            chk("hold_rd", 32'(im_rd_o), 32'd1);
            chk("hold_addr", im_addr_o, hold_addr);
        end
        hold_pend = im_rd_o && !im_ready_i;
        hold_addr = im_addr_o;
        if (im_rd_o) begin
            chk("issue_addr", im_addr_o, issue_pc);
            if (im_ready_i) begin
                memq.push_back('{addr: im_addr_o, due: cyc + $urandom_range(lat_max, lat_min)});
                issue_pc += 32'd4;
            end
        end
        if (f_valid_o) begin
            if (!f_stall_i && !bra) begin
                chk("pop_pc", f_pc_o, exp_pc);
                chk("pop_ir", f_ir_o, mdata(exp_pc));
                if (arm_first) begin first_pop_pc = f_pc_o; arm_first = 0; end
                if (f_pc_o == 32'h0 && prev_pop_pc == 32'hFFFF_FFFC) wrap_seen = 1;
                prev_pop_pc = f_pc_o;
                exp_pc += 32'd4;
                n_pop++;
            end
            last_pc = f_pc_o; last_ir = f_ir_o;
        end else begin
            chk("empty_pc", f_pc_o, last_pc);
            chk("empty_ir", f_ir_o, last_ir);
        end
        if (bra) begin
            exp_pc   = {tgt[31:2], 2'b00};
            issue_pc = exp_pc;
        end
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    task automatic arm();
        arm_first = 1; first_pop_pc = 32'hDEAD_BEEF;
    endtask

    initial begin
        int unsigned p0;
        bit found;
        logic [31:0] t;
        wrap_seen = 0; prev_pop_pc = 32'h1;

        // Reset release, zero-wait memory: latency and throughput
        do_reset();
        p0 = n_pop;
        repeat (10) step(1'b0, '0);
        chk("lat_rd_c0", 32'(rd_log[0]), 32'd0);
        chk("lat_rd_c1", 32'(rd_log[1]), 32'd1);
        chk("lat_val_c2", 32'(val_log[2]), 32'd0);
        chk("lat_val_c3", 32'(val_log[3]), 32'd1);
        chk("thru_pops", n_pop - p0, 32'd7);

        // Decode stall for 5 cycles, then release
        stall_pct = 100;
        repeat (5) step(1'b0, '0);
        chk("stall_rd_c10", 32'(rd_log[10]), 32'd0);
        chk("stall_rd_c14", 32'(rd_log[14]), 32'd0);
        stall_pct = 0;
        p0 = n_pop;
        repeat (10) step(1'b0, '0);
        chk("stall_release_pops", n_pop - p0, 32'd10);

        // 3-cycle memory, redirect with two requests in flight
        do_reset();
        lat_min = 3; lat_max = 3;
        for (int i = 0; i < 20 && memq.size() < 2; i++) step(1'b0, '0);
        chk("t3_inflight", 32'(memq.size()), 32'd2);
        arm();
        step(1'b1, 32'h0000_0100);
        repeat (20) step(1'b0, '0);
        chk("t3_first_pc", first_pop_pc, 32'h0000_0100);

        // Redirect coinciding with a response and a pop
        lat_min = 1; lat_max = 1;
        found = 0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (f_valid_o && memq.size() > 0 && memq[0].due <= cyc) found = 1;
            else step(1'b0, '0);
        end
        chk("t4_setup", 32'(found), 32'd1);
        arm();
        step(1'b1, 32'h0000_0180);
        repeat (15) step(1'b0, '0);
        chk("t4_first_pc", first_pop_pc, 32'h0000_0180);

        // Back-to-back redirects: latest target wins
        arm();
        step(1'b1, 32'h0000_0200);
        step(1'b1, 32'h0000_0300);
        repeat (20) step(1'b0, '0);
        chk("t5_first_pc", first_pop_pc, 32'h0000_0300);

        // Memory not ready for 4 cycles at 0x40
        rdy_pct = 0;
        step(1'b1, 32'h0000_0040);
        repeat (4) step(1'b0, '0);
        chk("t6_rd_held", 32'(last_rd), 32'd1);
        chk("t6_addr_held", last_addr, 32'h0000_0040);
        rdy_pct = 100;

        // Sequential fetch wraps from the top of the address space
        step(1'b1, 32'hFFFF_FFFE);
        repeat (12) step(1'b0, '0);
        chk("wrap_seen", 32'(wrap_seen), 32'd1);

        // Randomized traffic, with a reset in the middle
        stall_pct = 30; rdy_pct = 70; lat_min = 1; lat_max = 3;
        p0 = n_pop;
        for (int seg = 0; seg < 2; seg++) begin
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(99) < 3) begin
                    t = $urandom;
                    if ($urandom_range(7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
                    step(1'b1, t);
                end else begin
                    step(1'b0, '0);
                end
            end
            if (seg == 0) do_reset();
        end
        chk("rand_progress", 32'(n_pop - p0 > 300), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
